// File: rtl/axi_write_adapter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_write_adapter_pkg
//  Description : Shared types and constants for the AXI3 single-beat store
//                adapter. It holds the FSM encoding, the fixed AW attributes,
//                the response code and small helpers used by the datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_write_adapter_pkg;

    // Write-side FSM encoding (2-bit)
    typedef enum logic [1:0] {
        WRITE_IDLE   = 2'd0,
        WRITE_SEND   = 2'd1,
        WRITE_WAIT_B = 2'd2,
        WRITE_DONE   = 2'd3
    } write_state_e;

    // The block reset is active-high. The polarity is compared explicitly,
    // so it cannot be confused with the active-low reset used elsewhere.
    localparam logic C_RST_ACTIVE = 1'b1;

    // Handshake levels
    localparam logic C_VALID   = 1'b1;
    localparam logic C_INVALID = 1'b0;
    localparam logic C_READY   = 1'b1;

    // AXI response code for a successful write
    localparam logic [1:0] C_AXI_RESP_OKAY = 2'b00;

    // Fixed attributes of every write: one beat of 4 bytes, INCR, normal,
    // non-cacheable, privileged data access.
    localparam logic [3:0] C_AWLEN   = 4'd0;
    localparam logic [2:0] C_AWSIZE  = 3'b010;
    localparam logic [1:0] C_AWBURST = 2'b01;
    localparam logic [1:0] C_AWLOCK  = 2'b00;
    localparam logic [3:0] C_AWCACHE = 4'b0000;
    localparam logic [2:0] C_AWPROT  = 3'b001;

    // Clear the byte offset so the bus always sees a word address; the
    // byte lanes are selected by the strobes instead.
    function automatic logic [31:0] word_align(input logic [31:0] byte_addr);
        return byte_addr & 32'hFFFF_FFFC;
    endfunction

    // A store fails when the slave reports anything but OKAY or when the
    // response carries an ID that this master never issued.
    function automatic logic resp_is_error(
        input logic [1:0] resp,
        input logic [3:0] rsp_id,
        input logic [3:0] own_id
    );
        return (resp != C_AXI_RESP_OKAY) || (rsp_id != own_id);
    endfunction

endpackage : axi_write_adapter_pkg
`default_nettype wire

// File: rtl/axi_write_adapter.sv
`default_nettype none
// ============================================================================
//  Module      : axi_write_adapter
//  Description : AXI3 write-channel master for MEM-stage stores. Accepts one
//                store request, issues a single-beat write on AW/W with byte
//                strobes, waits for B and pulses completion (with an error
//                flag) for one cycle. One transaction outstanding at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_write_adapter
    import axi_write_adapter_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'b0001
) (
    input  logic        clk,
    input  logic        reset,

    // AXI write address channel
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,

    // AXI write data channel
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    // AXI write response channel
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,

    // MEM stage store interface
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_sel,
    output logic        mem_write_done,
    output logic        mem_write_err
);

    // ------------------------------------------------------------------
    // State and registered channel signals
    // ------------------------------------------------------------------
    write_state_e state_q, state_d;

    logic        awvalid_q, awvalid_d;
    logic        wvalid_q,  wvalid_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q,  w_done_d;
    logic [31:0] awaddr_q,  awaddr_d;
    logic [31:0] wdata_q,   wdata_d;
    logic [3:0]  wstrb_q,   wstrb_d;
    logic        err_q,     err_d;

    // Handshake and completion terms for the SEND phase
    logic w_aw_hs;
    logic w_w_hs;
    logic w_aw_complete;
    logic w_w_complete;
    logic w_req_has_bytes;

    // Per-channel handshakes; each valid depends only on its own ready
    always_comb begin
        w_aw_hs         = awvalid_q & awready;
        w_w_hs          = wvalid_q & wready;
        w_aw_complete   = aw_done_q | w_aw_hs;
        w_w_complete    = w_done_q | w_w_hs;
        w_req_has_bytes = (mem_sel != 4'b0000);
    end

    // Next-state and next-value logic for the FSM and both channel flags
    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        err_d     = err_q;

        case (state_q)
            WRITE_IDLE: begin
                if (mem_we) begin
                    err_d = 1'b0;
                    if (w_req_has_bytes) begin
                        // Capture the request; the MEM inputs are not
                        // looked at again until the next IDLE.
                        awaddr_d  = word_align(mem_addr);
                        wdata_d   = mem_wdata;
                        wstrb_d   = mem_sel;
                        awvalid_d = C_VALID;
                        wvalid_d  = C_VALID;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = WRITE_SEND;
                    end else begin
                        // Nothing to write: complete without touching the bus
                        state_d = WRITE_DONE;
                    end
                end
            end

            WRITE_SEND: begin
                if (w_aw_hs) begin
                    awvalid_d = C_INVALID;
                    aw_done_d = 1'b1;
                end
                if (w_w_hs) begin
                    wvalid_d = C_INVALID;
                    w_done_d = 1'b1;
                end
                // Covers both channels finishing on the same edge as well as
                // one channel finishing after the other.
                if (w_aw_complete && w_w_complete) begin
                    state_d = WRITE_WAIT_B;
                end
            end

            WRITE_WAIT_B: begin
                if (bvalid) begin
                    err_d   = resp_is_error(bresp, bid, AXI_ID);
                    state_d = WRITE_DONE;
                end
            end

            WRITE_DONE: begin
                // mem_we still belongs to the store just completed
                state_d = WRITE_IDLE;
            end

            default: begin
                state_d = WRITE_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (reset == C_RST_ACTIVE) begin
            state_q   <= WRITE_IDLE;
            awvalid_q <= C_INVALID;
            wvalid_q  <= C_INVALID;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            awaddr_q  <= 32'h0000_0000;
            wdata_q   <= 32'h0000_0000;
            wstrb_q   <= 4'b0000;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            err_q     <= err_d;
        end
    end

    // Bus-facing outputs; bready and the completion pulse decode the state
    always_comb begin
        awid    = AXI_ID;
        awaddr  = awaddr_q;
        awlen   = C_AWLEN;
        awsize  = C_AWSIZE;
        awburst = C_AWBURST;
        awlock  = C_AWLOCK;
        awcache = C_AWCACHE;
        awprot  = C_AWPROT;
        awvalid = awvalid_q;

        wid     = AXI_ID;
        wdata   = wdata_q;
        wstrb   = wstrb_q;
        wvalid  = wvalid_q;
        wlast   = wvalid_q;

        bready  = (state_q == WRITE_WAIT_B) ? C_READY : 1'b0;

        mem_write_done = (state_q == WRITE_DONE);
        mem_write_err  = (state_q == WRITE_DONE) & err_q;
    end

endmodule : axi_write_adapter
`default_nettype wire

// File: tb/tb_axi_write_adapter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_write_adapter
//  Description : Self-checking bench for axi_write_adapter. A responsive AXI
//                slave with programmable delays drives the bus; expected
//                addresses, strobes, errors and latencies come from tables
//                and from the store rules computed directly in the bench.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_write_adapter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_sel;
    logic        mem_write_done;
    logic        mem_write_err;

    int checks   = 0;
    int failures = 0;

    axi_write_adapter #(.AXI_ID(4'b0001)) dut (
        .clk            (clk),
        .reset          (reset),
        .awid           (awid),
        .awaddr         (awaddr),
        .awlen          (awlen),
        .awsize         (awsize),
        .awburst        (awburst),
        .awlock         (awlock),
        .awcache        (awcache),
        .awprot         (awprot),
        .awvalid        (awvalid),
        .awready        (awready),
        .wid            (wid),
        .wdata          (wdata),
        .wstrb          (wstrb),
        .wlast          (wlast),
        .wvalid         (wvalid),
        .wready         (wready),
        .bid            (bid),
        .bresp          (bresp),
        .bvalid         (bvalid),
        .bready         (bready),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_sel        (mem_sel),
        .mem_write_done (mem_write_done),
        .mem_write_err  (mem_write_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
        logic [1:0]  bresp;
        logic [3:0]  bid;
        int          awd;
        int          wd;
        int          bd;
        logic [31:0] exp_addr;
        logic [3:0]  exp_strb;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete store seen from the MEM side with a delaying slave.
    // Sample points sit 1 time unit after each rising edge; cycle count
    // cyc is the number of edges since the request was presented.
    task automatic do_store(
        input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
        input logic [1:0] br, input logic [3:0] bi,
        input int awd, input int wd, input int bd,
        input logic [31:0] exp_addr, input logic [3:0] exp_strb,
        input logic exp_err, input int exp_lat,
        input int req_edge, input bit follow
    );
        int cyc = 0;
        int aw_cnt = 0, w_cnt = 0, b_cnt = 0;
        int aw_seen = 0, w_seen = 0, b_wait = 0;
        bit seen_done = 0;
        bit zero = (s == 4'h0);

        mem_we = 1'b1; mem_addr = a; mem_wdata = d; mem_sel = s;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = br; bid = bi;

        while (!seen_done && cyc < 60) begin
            if (awvalid) begin awready = (aw_seen >= awd); aw_seen++; end
            else awready = 1'b0;
            if (wvalid) begin wready = (w_seen >= wd); w_seen++; end
            else wready = 1'b0;
            // AXI3 slave may respond once the write data is in, even
            // before the address handshake; bvalid persists until taken.
            if (w_cnt > 0 && b_cnt == 0) begin bvalid = (b_wait >= bd); b_wait++; end
            else bvalid = 1'b0;

            if (zero) begin
                check("no_bus_activity", {awvalid, wvalid}, 0);
            end else begin
                if (awvalid) check("awaddr", awaddr, exp_addr);
                if (wvalid) begin
                    check("wdata", wdata, d);
                    check("wstrb", wstrb, exp_strb);
                    check("wlast", wlast, 1);
                end
                if (aw_cnt > 0) check("awvalid_drop", awvalid, 0);
                if (w_cnt > 0)  check("wvalid_drop", wvalid, 0);
                if (aw_cnt == 0 || w_cnt == 0) check("bready_early", bready, 0);
            end

            if (awvalid && awready) aw_cnt++;
            if (wvalid && wready)   w_cnt++;
            if (bvalid && bready)   b_cnt++;

            tick();
            cyc++;
            if (cyc >= req_edge) begin
                mem_addr  = $urandom;
                mem_wdata = $urandom;
                mem_sel   = 4'($urandom);
            end
            if (mem_write_done) seen_done = 1'b1;
        end

        bvalid = 1'b0; awready = 1'b0; wready = 1'b0;
        check("done_seen", seen_done, 1);
        if (seen_done) begin
            check("done_err", mem_write_err, exp_err);
            if (exp_lat > 0) check("done_latency", cyc, exp_lat);
            check("aw_handshakes", aw_cnt, zero ? 0 : 1);
            check("w_handshakes", w_cnt, zero ? 0 : 1);
            check("b_handshakes", b_cnt, zero ? 0 : 1);
        end
        if (!follow) begin
            mem_we = 1'b0;
            tick();
            check("done_single_pulse", mem_write_done, 0);
            check("idle_after_done", {awvalid, wvalid, bready}, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit prev_follow;
        reset = 1'b1; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; mem_sel = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = 4'h1;

        //                addr          data          sel    br     bid   awd wd bd  exp_addr      strb  err lat
        vecs[0] = '{32'h8000_1004, 32'hDEAD_BEEF, 4'hF, 2'b00, 4'h1, 0, 0, 0, 32'h8000_1004, 4'hF, 1'b0, 3};
        vecs[1] = '{32'h0000_1003, 32'h7F00_0000, 4'h8, 2'b10, 4'h1, 0, 0, 0, 32'h0000_1000, 4'h8, 1'b1, 3};
        vecs[2] = '{32'h1234_5676, 32'h0000_BEEF, 4'h3, 2'b00, 4'h2, 0, 0, 0, 32'h1234_5674, 4'h3, 1'b1, 3};
        vecs[3] = '{32'h4000_0008, 32'hCAFE_F00D, 4'hF, 2'b00, 4'h1, 3, 0, 0, 32'h4000_0008, 4'hF, 1'b0, 6};
        vecs[4] = '{32'h0000_0010, 32'h1111_1111, 4'h0, 2'b00, 4'h1, 0, 0, 0, 32'h0000_0000, 4'h0, 1'b0, 1};
        vecs[5] = '{32'h0000_0FFC, 32'h0102_0304, 4'h6, 2'b11, 4'h1, 1, 2, 2, 32'h0000_0FFC, 4'h6, 1'b1, 7};

        // Reset state
        tick(); tick();
        check("rst_valids", {awvalid, wvalid, bready}, 0);
        check("rst_done", {mem_write_done, mem_write_err}, 0);
        check("rst_awaddr", awaddr, 0);
        check("rst_wdata", wdata, 0);
        check("rst_wstrb", wstrb, 0);
        check("const_awsize_burst_prot", {awsize, awburst, awprot}, {3'b010, 2'b01, 3'b001});
        check("const_ids_len", {awid, wid, awlen, awlock, awcache}, {4'h1, 4'h1, 4'h0, 2'b00, 4'h0});
        reset = 1'b0;
        tick();

        // Table-driven stores
        for (int i = 0; i < 6; i++) begin
            do_store(vecs[i].addr, vecs[i].data, vecs[i].sel, vecs[i].bresp, vecs[i].bid,
                     vecs[i].awd, vecs[i].wd, vecs[i].bd,
                     vecs[i].exp_addr, vecs[i].exp_strb, vecs[i].exp_err, vecs[i].exp_lat, 1, 0);
        end

        // Reset in the middle of SEND with both valids pending
        mem_we = 1'b1; mem_addr = 32'h0000_2000; mem_wdata = 32'hA5A5_A5A5; mem_sel = 4'hF;
        awready = 1'b0; wready = 1'b0;
        tick(); tick();
        check("send_awvalid_before_reset", awvalid, 1);
        reset = 1'b1;
        tick();
        check("reset_mid_valids", {awvalid, wvalid, bready}, 0);
        check("reset_mid_done", mem_write_done, 0);
        reset = 1'b0; mem_we = 1'b0;
        tick();
        check("after_reset_idle", {awvalid, wvalid, mem_write_done}, 0);
        do_store(32'h0000_2004, 32'h5555_AAAA, 4'hC, 2'b00, 4'h1, 0, 0, 0,
                 32'h0000_2004, 4'hC, 1'b0, 3, 1, 0);

        // Back-to-back: the second request is held through the DONE cycle
        do_store(32'h0000_3000, 32'h0000_0001, 4'hF, 2'b00, 4'h1, 0, 0, 0,
                 32'h0000_3000, 4'hF, 1'b0, 3, 1, 1);
        do_store(32'h0000_3005, 32'h0000_0200, 4'h2, 2'b00, 4'h1, 0, 0, 0,
                 32'h0000_3004, 4'h2, 1'b0, 4, 2, 0);

        // Randomised stores against the store rules
        prev_follow = 1'b0;
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a, d;
            logic [3:0]  s, bi;
            logic [1:0]  br;
            bit          fol;
            a  = $urandom;
            d  = $urandom;
            s  = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
            br = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            bi = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h1;
            fol = (n == 39) ? 1'b0 : 1'($urandom_range(0, 1));
            do_store(a, d, s, br, bi,
                     $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                     a & 32'hFFFF_FFFC, s,
                     (s != 4'h0) && ((br != 2'b00) || (bi != 4'h1)),
                     0, prev_follow ? 2 : 1, fol);
            prev_follow = fol;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_axi_write_adapter
`default_nettype wire
